// File: rtl/broadcast_arbiter.sv
// broadcast_arbiter: round-robin arbiter that collects finished FU results and
// drives up to NUM_BCAST registered common-data-bus lanes per cycle.
// Optional statistics counters are enabled with the macro BCAST_STATS_EN.
module broadcast_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 4,
   parameter int NUM_FU     = 4,
   parameter int NUM_BCAST  = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_FU-1:0]                fu_valid,
   input  logic [NUM_FU*TAG_WIDTH-1:0]      fu_tag,
   input  logic [NUM_FU*DATA_WIDTH-1:0]     fu_data,
   output logic [NUM_FU-1:0]                fu_ready,
   input  logic                             allowBroadcast,
   output logic                             broadcastDataAvailable,
   output logic [NUM_BCAST-1:0]             bcast_valid,
   output logic [NUM_BCAST*TAG_WIDTH-1:0]   bcast_tag,
   output logic [NUM_BCAST*DATA_WIDTH-1:0]  bcast_data,
   output logic                             ongoingBroadcast
`ifdef BCAST_STATS_EN
   ,
   output logic [31:0]                      stat_broadcasts,
   output logic [31:0]                      stat_conflicts
`endif
);

   localparam int PTR_W = $clog2(NUM_FU);
   localparam int CNT_W = $clog2(NUM_BCAST + 1);
   localparam logic [PTR_W:0]   FU_LIM  = (PTR_W + 1)'(NUM_FU);
   localparam logic [PTR_W-1:0] FU_LAST = PTR_W'(NUM_FU - 1);
   localparam logic [CNT_W-1:0] LANES   = CNT_W'(NUM_BCAST);

   logic [PTR_W-1:0]      rr_ptr;
   logic [PTR_W-1:0]      last_idx;
   logic [PTR_W-1:0]      next_ptr;
   logic [PTR_W:0]        scan_sum;
   logic [PTR_W-1:0]      scan_idx;
   logic [CNT_W-1:0]      n_grant;
   logic [NUM_FU-1:0]     grant;
   logic                  any_grant;
   logic [NUM_BCAST-1:0]  lane_vld;
   logic [PTR_W-1:0]      lane_src [NUM_BCAST];
   logic [TAG_WIDTH-1:0]  tag_arr  [NUM_FU];
   logic [DATA_WIDTH-1:0] data_arr [NUM_FU];

   logic [NUM_BCAST-1:0]            vld_p1;
   logic [NUM_BCAST*TAG_WIDTH-1:0]  tag_p1;
   logic [NUM_BCAST*DATA_WIDTH-1:0] data_p1;

   // Unpack the flat per-FU tag/data buses for lane selection.
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         tag_arr[i]  = fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
         data_arr[i] = fu_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Scan from rr_ptr, granting the first NUM_BCAST valid FUs; n-th grant feeds lane n.
   always_comb begin
      grant    = '0;
      lane_vld = '0;
      for (int k = 0; k < NUM_BCAST; k++) lane_src[k] = '0;
      last_idx = rr_ptr;
      n_grant  = '0;
      scan_sum = '0;
      scan_idx = '0;
      for (int j = 0; j < NUM_FU; j++) begin
         scan_sum = {1'b0, rr_ptr} + (PTR_W + 1)'(j);
         if (scan_sum >= FU_LIM) scan_sum = scan_sum - FU_LIM;
         scan_idx = scan_sum[PTR_W-1:0];
         if (allowBroadcast && fu_valid[scan_idx] && (n_grant < LANES)) begin
            grant[scan_idx] = 1'b1;
            for (int k = 0; k < NUM_BCAST; k++) begin
               if (n_grant == CNT_W'(k)) begin
                  lane_vld[k] = 1'b1;
                  lane_src[k] = scan_idx;
               end
            end
            last_idx = scan_idx;
            n_grant  = n_grant + CNT_W'(1);
         end
      end
      any_grant = |grant;
      next_ptr  = (last_idx == FU_LAST) ? '0 : last_idx + PTR_W'(1);
   end

   // Grants are suppressed while reset is held.
   always_comb begin
      fu_ready = rst ? grant : '0;
   end

   // Round-robin pointer moves past the last granted FU.
   always_ff @(posedge clk) begin
      if (!rst)           rr_ptr <= '0;
      else if (any_grant) rr_ptr <= next_ptr;
   end

   // ---- stage p1: registered broadcast lanes ----
   // Lanes pulse valid for one cycle; tag/data hold on idle lanes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_p1  <= '0;
         tag_p1  <= '0;
         data_p1 <= '0;
      end else begin
         vld_p1 <= lane_vld;
         for (int k = 0; k < NUM_BCAST; k++) begin
            if (lane_vld[k]) begin
               tag_p1[k*TAG_WIDTH +: TAG_WIDTH]    <= tag_arr[lane_src[k]];
               data_p1[k*DATA_WIDTH +: DATA_WIDTH] <= data_arr[lane_src[k]];
            end
         end
      end
   end

   assign bcast_valid            = vld_p1;
   assign bcast_tag              = tag_p1;
   assign bcast_data             = data_p1;
   assign ongoingBroadcast       = |vld_p1;
   assign broadcastDataAvailable = |fu_valid;

`ifdef BCAST_STATS_EN
   // Wrapping counters of lane broadcasts and oversubscribed granting cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_broadcasts <= '0;
         stat_conflicts  <= '0;
      end else begin
         stat_broadcasts <= stat_broadcasts + 32'($countones(vld_p1));
         if (allowBroadcast && ($countones(fu_valid) > NUM_BCAST))
            stat_conflicts <= stat_conflicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_broadcast_arbiter.sv
// Bench for broadcast_arbiter: one-lane and two-lane instances share stimulus;
// a queue-based model checks every cycle, directed literals pin key scenarios.
module tb_broadcast_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  fu_valid;
   logic [15:0] fu_tag;
   logic [127:0] fu_data;
   logic        allow;

   logic [3:0]  rdy1, rdy2;
   logic        bda1, bda2, ob1, ob2;
   logic [0:0]  bv1;
   logic [1:0]  bv2;
   logic [3:0]  bt1;
   logic [7:0]  bt2;
   logic [31:0] bd1;
   logic [63:0] bd2;
`ifdef BCAST_STATS_EN
   logic [31:0] sb1, sc1, sb2, sc2;
`endif

   int checks = 0;
   int errors = 0;

   broadcast_arbiter #(.DATA_WIDTH(32), .TAG_WIDTH(4), .NUM_FU(4), .NUM_BCAST(1)) u1 (
      .clk(clk), .rst(rst), .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data),
      .fu_ready(rdy1), .allowBroadcast(allow), .broadcastDataAvailable(bda1),
      .bcast_valid(bv1), .bcast_tag(bt1), .bcast_data(bd1), .ongoingBroadcast(ob1)
`ifdef BCAST_STATS_EN
      , .stat_broadcasts(sb1), .stat_conflicts(sc1)
`endif
   );

   broadcast_arbiter #(.DATA_WIDTH(32), .TAG_WIDTH(4), .NUM_FU(4), .NUM_BCAST(2)) u2 (
      .clk(clk), .rst(rst), .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data),
      .fu_ready(rdy2), .allowBroadcast(allow), .broadcastDataAvailable(bda2),
      .bcast_valid(bv2), .bcast_tag(bt2), .bcast_data(bd2), .ongoingBroadcast(ob2)
`ifdef BCAST_STATS_EN
      , .stat_broadcasts(sb2), .stat_conflicts(sc2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_default();
      for (int i = 0; i < 4; i++) begin
         fu_tag[i*4 +: 4]    = 4'(8 + i);
         fu_data[i*32 +: 32] = 32'hA000_0000 | 32'(i);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_ptr  [2];
   logic [1:0]  m_bv   [2];
   logic [3:0]  m_tag  [2][2];
   logic [31:0] m_data [2][2];
   logic [31:0] m_sb   [2];
   logic [31:0] m_sc   [2];
   bit          model_ok = 0;

   always @(negedge clk) begin
      int nb;
      int q[$];
      logic [3:0] er;
      logic [63:0] a_rdy, a_bv, a_tag, a_data, a_bda, a_ob;
      for (int u = 0; u < 2; u++) begin
         nb = u + 1;
         q.delete();
         er = '0;
         if (rst && allow) begin
            for (int j = 0; j < 4; j++) begin
               int idx;
               idx = (m_ptr[u] + j) % 4;
               if (fu_valid[idx] && q.size() < nb) begin
                  q.push_back(idx);
                  er[idx] = 1'b1;
               end
            end
         end
         if (model_ok) begin
            a_rdy = (u == 0) ? 64'(rdy1) : 64'(rdy2);
            a_bv  = (u == 0) ? 64'(bv1)  : 64'(bv2);
            a_bda = (u == 0) ? 64'(bda1) : 64'(bda2);
            a_ob  = (u == 0) ? 64'(ob1)  : 64'(ob2);
            chk($sformatf("u%0d fu_ready", nb), a_rdy, 64'(er));
            chk($sformatf("u%0d bcast_valid", nb), a_bv, 64'(m_bv[u] & 2'(nb == 2 ? 3 : 1)));
            chk($sformatf("u%0d broadcastDataAvailable", nb), a_bda, 64'(|fu_valid));
            chk($sformatf("u%0d ongoingBroadcast", nb), a_ob, 64'(|m_bv[u]));
            for (int k = 0; k < nb; k++) begin
               a_tag  = (u == 0) ? 64'(bt1) : 64'(bt2[k*4 +: 4]);
               a_data = (u == 0) ? 64'(bd1) : 64'(bd2[k*32 +: 32]);
               chk($sformatf("u%0d lane%0d tag", nb, k), a_tag, 64'(m_tag[u][k]));
               chk($sformatf("u%0d lane%0d data", nb, k), a_data, 64'(m_data[u][k]));
            end
`ifdef BCAST_STATS_EN
            chk($sformatf("u%0d stat_broadcasts", nb), (u == 0) ? 64'(sb1) : 64'(sb2), 64'(m_sb[u]));
            chk($sformatf("u%0d stat_conflicts", nb), (u == 0) ? 64'(sc1) : 64'(sc2), 64'(m_sc[u]));
`endif
         end
         // state the DUT must hold after the coming edge
         if (!rst) begin
            m_ptr[u] = 0;
            m_bv[u]  = '0;
            m_sb[u]  = '0;
            m_sc[u]  = '0;
            for (int k = 0; k < 2; k++) begin
               m_tag[u][k]  = '0;
               m_data[u][k] = '0;
            end
         end else begin
            m_sb[u] = m_sb[u] + 32'($countones(m_bv[u]));
            if (allow && ($countones(fu_valid) > nb)) m_sc[u] = m_sc[u] + 32'd1;
            m_bv[u] = '0;
            for (int k = 0; k < q.size(); k++) begin
               m_bv[u][k]   = 1'b1;
               m_tag[u][k]  = fu_tag[q[k]*4 +: 4];
               m_data[u][k] = fu_data[q[k]*32 +: 32];
            end
            if (q.size() > 0) m_ptr[u] = (q[q.size()-1] + 1) % 4;
         end
      end
      if (!rst) model_ok = 1;
   end

   // ---------------- directed stimulus ----------------
   logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [3:0] exp_t [5] = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd8};

   initial begin
      rst = 1'b0; allow = 1'b1; fu_valid = 4'hF; fu_tag = '0; fu_data = '0;
      set_default();
      tick();
      @(negedge clk);
      chk("reset bcast_valid", 64'(bv1), 64'd0);
      chk("reset bcast_tag", 64'(bt1), 64'd0);
      chk("reset bcast_data", 64'(bd1), 64'd0);
      chk("reset fu_ready forced", 64'(rdy1), 64'd0);
      chk("reset data available", 64'(bda1), 64'd1);
      tick();

      // single requester FU2
      rst = 1'b1; fu_valid = 4'b0100;
      fu_tag[8 +: 4] = 4'd5; fu_data[64 +: 32] = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("single grant u1", 64'(rdy1), 64'h4);
      chk("single grant u2", 64'(rdy2), 64'h4);
      tick();
      fu_valid = 4'b0000;
      @(negedge clk);
      chk("single bcast_valid", 64'(bv1), 64'd1);
      chk("single bcast_tag", 64'(bt1), 64'd5);
      chk("single bcast_data", 64'(bd1), 64'hDEAD_BEEF);
      chk("single u2 bcast_valid", 64'(bv2), 64'b01);
      tick();
      set_default();

      // wrap 3->0 on the two-lane instance (pointer now 3)
      fu_valid = 4'b1011;
      @(negedge clk);
      chk("wrap grant", 64'(rdy2), 64'b1001);
      tick();
      fu_valid = 4'b0010;
      @(negedge clk);
      chk("wrap bcast_valid", 64'(bv2), 64'b11);
      chk("wrap bcast_tag", 64'(bt2), 64'h8B);
      chk("wrap bcast_data", bd2, 64'hA000_0000_A000_0003);
      chk("wrap next grant FU1", 64'(rdy2), 64'b0010);
      tick();
      fu_valid = 4'b0000;
      @(negedge clk);
      chk("wrap lane1 holds", 64'(bt2), 64'h89);
      tick();

      // full contention from pointer 0
      rst = 1'b0;
      tick();
      rst = 1'b1; fu_valid = 4'hF;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("contention grant %0d", c), 64'(rdy1), 64'(exp_g[c]));
         if (c > 0) chk($sformatf("contention tag %0d", c), 64'(bt1), 64'(exp_t[c-1]));
         tick();
      end
      fu_valid = 4'b0000;
      @(negedge clk);
      chk("contention last bcast", 64'(bt1), 64'(exp_t[4]));
      chk("contention last valid", 64'(bv1), 64'd1);
      tick();
      @(negedge clk);
`ifdef BCAST_STATS_EN
      chk("stats broadcasts u2", 64'(sb2), 64'd10);
      chk("stats conflicts u2", 64'(sc2), 64'd5);
      chk("stats broadcasts u1", 64'(sb1), 64'd5);
`endif
      chk("idle no broadcast", 64'(ob1), 64'd0);
      tick();

      // stall: pointer is 1
      allow = 1'b0; fu_valid = 4'b0110;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("stall fu_ready", 64'(rdy1), 64'd0);
         chk("stall bcast_valid", 64'(bv1), 64'd0);
         tick();
      end
      allow = 1'b1;
      @(negedge clk);
      chk("release grants FU1", 64'(rdy1), 64'b0010);
      tick();
      allow = 1'b0; fu_valid = 4'b0100;
      @(negedge clk);
      chk("allow drop bcast still shown", 64'(bv1), 64'd1);
      chk("allow drop bcast tag", 64'(bt1), 64'd9);
      chk("allow drop no grant", 64'(rdy1), 64'd0);
      tick();

      // reset mid-operation: pointer is 2
      allow = 1'b1; fu_valid = 4'b0111;
      @(negedge clk);
      chk("pre-reset grant FU2", 64'(rdy1), 64'b0100);
      tick();
      rst = 1'b0; fu_valid = 4'b0011;
      @(negedge clk);
      chk("reset cycle fu_ready", 64'(rdy1), 64'd0);
      tick();
      @(negedge clk);
      chk("after reset bcast_valid", 64'(bv1), 64'd0);
      chk("after reset fu_ready", 64'(rdy1), 64'd0);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rearbitrate from 0", 64'(rdy1), 64'b0001);
      tick();
      fu_valid = 4'b0010;
      @(negedge clk);
      chk("rearbitrate FU1", 64'(rdy1), 64'b0010);
      tick();

      // mixed patterns, checked by the model alone
      for (int c = 0; c < 40; c++) begin
         fu_valid = 4'($urandom_range(0, 15));
         allow    = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 4; i++) begin
            fu_tag[i*4 +: 4]    = 4'($urandom_range(0, 15));
            fu_data[i*32 +: 32] = $urandom;
         end
         tick();
      end
      fu_valid = 4'b0000;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/broadcast_arbiter.md
# broadcast_arbiter

Parametrised result-broadcast arbiter. It collects completed results (tag + data) from `NUM_FU` functional units and drives up to `NUM_BCAST` common-data-bus lanes per cycle. Arbitration is round-robin and the output stage is registered. It sits between the dispatch/execution side and the reorder buffer/register file broadcast inputs. It replaces the single-lane broadcast path and adds multi-lane issue, fairness and backpressure from the arbitration unit.

## Interface
Parameters:
- `DATA_WIDTH`, 32, result data width.
- `TAG_WIDTH`, 4, ROB tag width.
- `NUM_FU`, 4, number of requesting functional units (≥2).
- `NUM_BCAST`, 1, broadcast lanes (1..`NUM_FU`).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `fu_valid`  in  `NUM_FU`  FU i holds a finished result.
- `fu_tag`  in  `NUM_FU*TAG_WIDTH`  per-FU destination tag; FU i at bits [i*TAG_WIDTH +: TAG_WIDTH].
- `fu_data`  in  `NUM_FU*DATA_WIDTH`  per-FU result, same packing.
- `fu_ready`  out  `NUM_FU`  grant; the result transfers in any cycle where `fu_valid[i] & fu_ready[i]`.
- `allowBroadcast`  in  1  broadcast permission from the arbitration unit.
- `broadcastDataAvailable`  out  1  |`fu_valid` (combinational).
- `bcast_valid`  out  `NUM_BCAST`  lane k carries a broadcast this cycle.
- `bcast_tag`  out  `NUM_BCAST*TAG_WIDTH`  lane tags.
- `bcast_data`  out  `NUM_BCAST*DATA_WIDTH`  lane data.
- `ongoingBroadcast`  out  1  |`bcast_valid`.

## Operation
- **Arbiter state:** a round-robin pointer `rr_ptr` (range 0..`NUM_FU`-1).
- **Grant when `allowBroadcast`=1:**
  - Scan FUs in order `rr_ptr`, `rr_ptr`+1, … mod `NUM_FU`.
  - Grant the first `NUM_BCAST` FUs with `fu_valid`=1 by setting their `fu_ready`.
  - The n-th grant in scan order maps to lane n.
- **Grant when `allowBroadcast`=0:** all `fu_ready`=0 and `rr_ptr` holds.
- **Pointer update:** on any grant, `rr_ptr` ← (index of the last granted FU + 1) mod `NUM_FU`. With no grant, `rr_ptr` holds. Wrap from `NUM_FU`-1 goes to 0.
- **`fu_ready` properties:**
  - Combinational from `fu_valid`, `rr_ptr` and `allowBroadcast`.
  - Never asserted for an FU with `fu_valid`=0.
- **FU obligations:** an FU holds `fu_valid`, tag and data stable until `fu_ready` is seen.
- **Output stage:**
  - Each lane k is registered: `bcast_valid[k]` ← lane k granted.
  - On a grant, `bcast_tag`/`bcast_data` lane k ← the granted FU's tag/data.
  - Ungranted lanes have `bcast_valid`=0; their tag and data hold their previous value.
- **Pulse semantics:** each broadcast is a one-cycle pulse. Consumers latch it and there is no downstream backpressure.
- **Tag uniqueness:** tags are unique per in-flight instruction and are not checked.
- **Reset (`rst`=0 at a clock edge):**
  - `rr_ptr`=0; `bcast_valid`=0; `bcast_tag`=0; `bcast_data`=0; stats counters = 0.
  - Combinational outputs follow their inputs during reset, except `fu_ready`, which is forced to 0 while `rst`=0.
  - A reset mid-transfer drops the pending registered broadcast.

## Timing
- Grant to broadcast latency is 1 cycle: a transfer at edge t appears on `bcast_*` during cycle t+1.
- Throughput: up to `NUM_BCAST` results per cycle, sustained.
- **Fairness:** a continuously valid FU is granted within ceil(`NUM_FU`/`NUM_BCAST`) granting cycles.
- **`allowBroadcast` dropping while a broadcast is registered:** the registered broadcast still appears; no new grants are made.
- **Same-cycle handoff:** the same FU may be re-granted in the cycle after its transfer if it presents a new result and it is next in scan order.

## Configuration
- **`BCAST_STATS_EN` defined:** adds two 32-bit outputs, both wrapping at 2^32.
  - `stat_broadcasts`: running count of lane broadcasts, incremented by popcount(`bcast_valid`) each cycle.
  - `stat_conflicts`: cycles where `allowBroadcast`=1 and popcount(`fu_valid`) > `NUM_BCAST`.
- **Not defined:** the ports and counters are absent; all other behaviour is identical.

## Test plan
- **Single requester:** `NUM_FU`=4, `NUM_BCAST`=1, only FU2 valid with tag 5, data 0xDEADBEEF.
  - `fu_ready[2]`=1 the same cycle.
  - Next cycle `bcast_valid`=1, tag 5, data 0xDEADBEEF.
  - `rr_ptr` becomes 3.
- **Full contention:** all four FUs held valid, `NUM_BCAST`=1, `rr_ptr`=0.
  - Grants go 0,1,2,3,0 on consecutive cycles.
  - Broadcasts follow one cycle later, one per cycle.
- **Wrap across 3→0:** `NUM_BCAST`=2, `rr_ptr`=3, FUs 0, 1, 3 valid.
  - FU3 goes to lane 0 and FU0 to lane 1.
  - `rr_ptr` becomes 1; FU1 is granted next cycle.
- **Stall:** FUs 1 and 2 valid with `allowBroadcast`=0 for 3 cycles.
  - `fu_ready`=0 and `bcast_valid`=0 throughout; `rr_ptr` is unchanged.
  - On release, FU1 is granted first.
- **Reset mid-operation:** `rst`=0 in the cycle after a grant.
  - The next cycle shows `bcast_valid`=0, `rr_ptr`=0, `fu_ready`=0.
  - After release, the un-granted FUs are re-arbitrated from 0.
- **Stats (`BCAST_STATS_EN`):** 4 FUs valid with `NUM_BCAST`=2 for 5 cycles.
  - `stat_broadcasts` = 10 after the 6th cycle.
  - `stat_conflicts` = 5.
